// File: rtl/relay_pkg.sv
// relay_pkg: shared types and bus widths for the relay computer datapath units
package relay_pkg;

    localparam int ADDR_W = 16;
    localparam int DATA_W = 8;

    typedef enum logic [2:0] {
        IDLE,
        SETUP,
        STROBE,
        HOLD,
        DRIVE
    } mem_state_t;

endpackage

// File: rtl/mem_wait_counter.sv
// mem_wait_counter: 4-bit loadable down-counter with zero flag for strobe timing
module mem_wait_counter (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       load,
    input  logic [3:0] load_val,
    input  logic       dec,
    output logic       zero
);

    logic [3:0] count;

    assign zero = (count == 4'd0);

    // load takes priority; decrement saturates at zero
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) count <= 4'd0;
        else count <= load ? load_val : (dec && !zero) ? count - 4'd1 : count;
    end

endmodule

// File: rtl/mem_access_unit.sv
// mem_access_unit: sequences setup/strobe/hold SRAM accesses for the control bus
module mem_access_unit #(
    parameter int ADDR_W      = 16,
    parameter int DATA_W      = 8,
    parameter int WAIT_CYCLES = 2
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              mem_read,
    input  logic              mem_write,
    input  logic [ADDR_W-1:0] addr_in,
    input  logic [DATA_W-1:0] data_in,
    output logic [DATA_W-1:0] data_out,
    output logic              data_oe,
    output logic [ADDR_W-1:0] sram_addr,
    output logic [DATA_W-1:0] sram_wdata,
    input  logic [DATA_W-1:0] sram_rdata,
    output logic              sram_ce_n,
    output logic              sram_oe_n,
    output logic              sram_we_n,
    output logic              busy,
    output logic              done,
    output logic              req_err,
    output logic              led_rd,
    output logic              led_wr
);

    import relay_pkg::*;

    localparam logic [3:0] WAIT_LOAD = 4'(WAIT_CYCLES - 1);

    mem_state_t state, next;
    logic       is_rd;
    logic       nxt_rd;
    logic       cnt_zero;
    logic       start_rd;
    logic       start_wr;
    logic       next_active;

    assign start_rd    = (state == IDLE) && mem_read && !mem_write;
    assign start_wr    = (state == IDLE) && mem_write && !mem_read;
    assign nxt_rd      = (state == IDLE) ? start_rd : is_rd;
    assign next_active = (next == SETUP) || (next == STROBE) || (next == HOLD);

    mem_wait_counter u_wait (
        .clk      (clk),
        .rst_n    (rst_n),
        .load     (state == SETUP),
        .load_val (WAIT_LOAD),
        .dec      (state == STROBE),
        .zero     (cnt_zero)
    );

    // state register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else state <= next;
    end

    // next-state logic
    always_comb begin
        next = state;
        case (state)
            IDLE:    next = (start_rd || start_wr) ? SETUP : IDLE;
            SETUP:   next = STROBE;
            STROBE:  next = cnt_zero ? HOLD : STROBE;
            HOLD:    next = is_rd ? DRIVE : IDLE;
            DRIVE:   next = IDLE;
            default: next = IDLE;
        endcase
    end

    // strobes and status are registered from the next state so the SRAM pins never glitch
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sram_ce_n <= 1'b1;
            sram_oe_n <= 1'b1;
            sram_we_n <= 1'b1;
            busy      <= 1'b0;
            led_rd    <= 1'b0;
            led_wr    <= 1'b0;
            data_oe   <= 1'b0;
            done      <= 1'b0;
        end else begin
            sram_ce_n <= !next_active;
            sram_oe_n <= !((next == STROBE) && nxt_rd);
            sram_we_n <= !((next == STROBE) && !nxt_rd);
            busy      <= (next != IDLE);
            led_rd    <= (next != IDLE) && nxt_rd;
            led_wr    <= (next != IDLE) && !nxt_rd;
            data_oe   <= (next == DRIVE);
            done      <= ((state == HOLD) && !is_rd) || (state == DRIVE);
        end
    end

    // address/data latch, read capture and sticky request error
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            is_rd      <= 1'b0;
            sram_addr  <= '0;
            sram_wdata <= '0;
            data_out   <= '0;
            req_err    <= 1'b0;
        end else begin
            if (start_rd || start_wr) begin
                is_rd     <= start_rd;
                sram_addr <= addr_in;
            end
            if (start_wr) sram_wdata <= data_in;
            if ((state == STROBE) && cnt_zero && is_rd) data_out <= sram_rdata;
            if ((state == IDLE && mem_read && mem_write) || (state != IDLE && (mem_read || mem_write)))
                req_err <= 1'b1;
        end
    end

endmodule

// File: tb/tb_mem_access_unit.sv
// tb_mem_access_unit: scoreboard bench for the SRAM access sequencer
module tb_mem_access_unit;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        mem_read = 1'b0;
    logic        mem_write = 1'b0;
    logic [15:0] addr_in = '0;
    logic [7:0]  data_in = '0;
    logic [7:0]  data_out;
    logic        data_oe;
    logic [15:0] sram_addr;
    logic [7:0]  sram_wdata;
    logic [7:0]  sram_rdata;
    logic        sram_ce_n, sram_oe_n, sram_we_n;
    logic        busy, done, req_err, led_rd, led_wr;

    mem_access_unit #(.ADDR_W(16), .DATA_W(8), .WAIT_CYCLES(2)) dut (
        .clk(clk), .rst_n(rst_n), .mem_read(mem_read), .mem_write(mem_write),
        .addr_in(addr_in), .data_in(data_in), .data_out(data_out), .data_oe(data_oe),
        .sram_addr(sram_addr), .sram_wdata(sram_wdata), .sram_rdata(sram_rdata),
        .sram_ce_n(sram_ce_n), .sram_oe_n(sram_oe_n), .sram_we_n(sram_we_n),
        .busy(busy), .done(done), .req_err(req_err), .led_rd(led_rd), .led_wr(led_wr)
    );

    always #5 clk = ~clk;

    // SRAM model (written by DUT strobes) and the bench's independent expectation of its contents
    logic [7:0] mem     [0:65535];
    logic [7:0] exp_mem [0:65535];
    assign sram_rdata = mem[sram_addr];

    typedef struct {
        bit          rd;
        logic [15:0] addr;
        logic [7:0]  data;
    } txn_t;
    txn_t exp_q[$];

    int checks = 0;
    int passes = 0;
    int we_cyc = 0;
    int oe_cyc = 0;
    int acc_cnt = 0;
    int viol = 0;
    logic prev_ce = 1'b1;

    // mid-cycle monitor: strobe widths, access starts, protocol violations, SRAM writes
    always @(negedge clk) begin
        if (!sram_we_n) we_cyc++;
        if (!sram_oe_n) oe_cyc++;
        if ((!sram_we_n && !sram_oe_n) || (!sram_we_n && sram_ce_n)) viol++;
        if (prev_ce && !sram_ce_n) acc_cnt++;
        prev_ce = sram_ce_n;
        if (!sram_we_n && !sram_ce_n) mem[sram_addr] = sram_wdata;
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic issue(input bit rd, input logic [15:0] a, input logic [7:0] d);
        txn_t t;
        t.rd = rd;
        t.addr = a;
        t.data = rd ? exp_mem[a] : d;
        if (!rd) exp_mem[a] = d;
        exp_q.push_back(t);
        mem_read = rd;
        mem_write = !rd;
        addr_in = a;
        data_in = d;
        we_cyc = 0;
        oe_cyc = 0;
        cyc();
        mem_read = 1'b0;
        mem_write = 1'b0;
    endtask

    task automatic wait_done(input int budget, output int lat, output int oe_seen,
                             output logic [7:0] oe_data, output int unstable);
        lat = -1;
        oe_seen = 0;
        oe_data = 'x;
        unstable = 0;
        for (int k = 1; k <= budget; k++) begin
            cyc();
            if (data_oe) begin
                oe_seen++;
                oe_data = data_out;
            end
            if (!sram_ce_n && (sram_addr !== exp_q[0].addr || (!exp_q[0].rd && sram_wdata !== exp_q[0].data)))
                unstable++;
            if (done) begin
                lat = k;
                break;
            end
        end
    endtask

    task automatic test_reset();
        cyc();
        cyc();
        checks++; if ({sram_ce_n, sram_oe_n, sram_we_n} !== 3'b111) $display("FAIL reset_strobes got %b exp 111", {sram_ce_n, sram_oe_n, sram_we_n}); else passes++;
        checks++; if ({data_oe, busy, done, req_err, led_rd, led_wr} !== 6'b0) $display("FAIL reset_status got %b exp 000000", {data_oe, busy, done, req_err, led_rd, led_wr}); else passes++;
        checks++; if ({sram_addr, sram_wdata, data_out} !== 32'h0) $display("FAIL reset_buses got %h exp 0", {sram_addr, sram_wdata, data_out}); else passes++;
        rst_n = 1'b1;
        cyc();
        checks++; if (busy !== 1'b0 || sram_ce_n !== 1'b1) $display("FAIL post_reset_idle got busy=%b ce_n=%b exp 0/1", busy, sram_ce_n); else passes++;
    endtask

    task automatic test_read();
        int lat, oes, uns;
        logic [7:0] od;
        txn_t t;
        mem[16'h1234] = 8'hA5;
        exp_mem[16'h1234] = 8'hA5;
        issue(1'b1, 16'h1234, 8'h00);
        checks++; if (sram_addr !== 16'h1234) $display("FAIL read_addr_latch got %h exp 1234", sram_addr); else passes++;
        checks++; if ({busy, led_rd, led_wr, sram_ce_n} !== 4'b1100) $display("FAIL read_setup got %b exp 1100", {busy, led_rd, led_wr, sram_ce_n}); else passes++;
        wait_done(20, lat, oes, od, uns);
        t = exp_q.pop_front();
        checks++; if (lat !== 5) $display("FAIL read_latency got %0d exp 5", lat); else passes++;
        checks++; if (oe_cyc !== 2 || we_cyc !== 0) $display("FAIL read_strobes got oe=%0d we=%0d exp 2/0", oe_cyc, we_cyc); else passes++;
        checks++; if (oes !== 1 || od !== t.data) $display("FAIL read_drive got cycles=%0d data=%h exp 1/%h", oes, od, t.data); else passes++;
        checks++; if (data_out !== t.data || data_oe !== 1'b0) $display("FAIL read_hold got data=%h oe=%b exp %h/0", data_out, data_oe, t.data); else passes++;
        checks++; if ({busy, led_rd, uns} !== {2'b00, 32'd0}) $display("FAIL read_end got busy=%b led=%b unstable=%0d exp 0/0/0", busy, led_rd, uns); else passes++;
        cyc();
        checks++; if (done !== 1'b0) $display("FAIL done_pulse_width got %b exp 0", done); else passes++;
    endtask

    task automatic test_write();
        int lat, oes, uns;
        logic [7:0] od;
        txn_t t;
        issue(1'b0, 16'hFFFF, 8'h3C);
        checks++; if ({sram_addr, sram_wdata, led_wr, led_rd} !== {16'hFFFF, 8'h3C, 2'b10}) $display("FAIL write_latch got %h/%h led=%b%b exp ffff/3c 10", sram_addr, sram_wdata, led_wr, led_rd); else passes++;
        wait_done(20, lat, oes, od, uns);
        t = exp_q.pop_front();
        checks++; if (lat !== 4) $display("FAIL write_latency got %0d exp 4", lat); else passes++;
        checks++; if (we_cyc !== 2 || oe_cyc !== 0) $display("FAIL write_strobes got we=%0d oe=%0d exp 2/0", we_cyc, oe_cyc); else passes++;
        checks++; if (uns !== 0 || oes !== 0) $display("FAIL write_stable got unstable=%0d data_oe=%0d exp 0/0", uns, oes); else passes++;
        checks++; if (mem[t.addr] !== t.data) $display("FAIL write_sram got %h exp %h", mem[t.addr], t.data); else passes++;
        checks++; if (busy !== 1'b0 || led_wr !== 1'b0) $display("FAIL write_end got busy=%b led=%b exp 0/0", busy, led_wr); else passes++;
    endtask

    task automatic test_back_to_back();
        int lat, oes, uns;
        logic [7:0] od;
        txn_t t;
        issue(1'b0, 16'h0200, 8'h5C);
        wait_done(20, lat, oes, od, uns);
        t = exp_q.pop_front();
        issue(1'b1, 16'h0200, 8'h00);
        wait_done(20, lat, oes, od, uns);
        t = exp_q.pop_front();
        checks++; if (lat !== 5 || od !== t.data) $display("FAIL b2b_readback got lat=%0d data=%h exp 5/%h", lat, od, t.data); else passes++;
    endtask

    task automatic test_addr_change();
        int lat, oes, uns;
        logic [7:0] od;
        txn_t t;
        issue(1'b1, 16'h0100, 8'h00);
        addr_in = 16'h0200;
        wait_done(20, lat, oes, od, uns);
        t = exp_q.pop_front();
        checks++; if (uns !== 0 || sram_addr !== 16'h0100) $display("FAIL addr_change got unstable=%0d addr=%h exp 0/0100", uns, sram_addr); else passes++;
        checks++; if (od !== t.data) $display("FAIL addr_change_data got %h exp %h", od, t.data); else passes++;
    endtask

    task automatic test_busy_request();
        int lat, dcnt, acc0;
        logic [7:0] od;
        txn_t t;
        mem[16'h0010] = 8'h77;
        exp_mem[16'h0010] = 8'h77;
        checks++; if (req_err !== 1'b0) $display("FAIL busy_req_pre got %b exp 0", req_err); else passes++;
        acc0 = acc_cnt;
        issue(1'b1, 16'h0010, 8'h00);
        lat = -1;
        od = 'x;
        for (int k = 1; k <= 20; k++) begin
            cyc();
            if (k == 1) begin
                mem_write = 1'b1;
                addr_in = 16'h0BAD;
                data_in = 8'hEE;
            end
            if (k == 2) mem_write = 1'b0;
            if (data_oe) od = data_out;
            if (done) begin
                lat = k;
                break;
            end
        end
        t = exp_q.pop_front();
        checks++; if (lat !== 5 || od !== t.data) $display("FAIL busy_req_read got lat=%0d data=%h exp 5/%h", lat, od, t.data); else passes++;
        checks++; if (req_err !== 1'b1) $display("FAIL busy_req_err got %b exp 1", req_err); else passes++;
        dcnt = 0;
        for (int k = 0; k < 8; k++) begin
            cyc();
            if (done || busy) dcnt++;
        end
        checks++; if (acc_cnt - acc0 !== 1 || dcnt !== 0) $display("FAIL busy_req_single got accesses=%0d extra=%0d exp 1/0", acc_cnt - acc0, dcnt); else passes++;
        checks++; if (mem[16'h0BAD] !== exp_mem[16'h0BAD]) $display("FAIL busy_req_nowrite got %h exp %h", mem[16'h0BAD], exp_mem[16'h0BAD]); else passes++;
    endtask

    task automatic test_reset_mid_access();
        int lat, oes, uns, dcnt;
        logic [7:0] od;
        txn_t t;
        issue(1'b0, 16'h0055, 8'h99);
        cyc();
        cyc();
        checks++; if (sram_we_n !== 1'b0) $display("FAIL rst_mid_strobe got we_n=%b exp 0", sram_we_n); else passes++;
        rst_n = 1'b0;
        #1;
        checks++; if ({sram_we_n, sram_ce_n, busy, led_wr, req_err} !== 5'b11000) $display("FAIL rst_mid_async got %b exp 11000", {sram_we_n, sram_ce_n, busy, led_wr, req_err}); else passes++;
        cyc();
        rst_n = 1'b1;
        exp_q.delete();
        dcnt = 0;
        for (int k = 0; k < 8; k++) begin
            cyc();
            if (done || busy) dcnt++;
        end
        checks++; if (dcnt !== 0) $display("FAIL rst_mid_nodone got %0d exp 0", dcnt); else passes++;
        issue(1'b1, 16'h1234, 8'h00);
        wait_done(20, lat, oes, od, uns);
        t = exp_q.pop_front();
        checks++; if (lat !== 5 || od !== t.data) $display("FAIL rst_mid_reread got lat=%0d data=%h exp 5/%h", lat, od, t.data); else passes++;
    endtask

    task automatic test_simultaneous();
        int acc0;
        acc0 = acc_cnt;
        checks++; if (req_err !== 1'b0) $display("FAIL simul_pre got %b exp 0", req_err); else passes++;
        mem_read = 1'b1;
        mem_write = 1'b1;
        addr_in = 16'h0300;
        cyc();
        mem_read = 1'b0;
        mem_write = 1'b0;
        checks++; if ({req_err, busy, sram_ce_n} !== 3'b101) $display("FAIL simul_err got %b exp 101", {req_err, busy, sram_ce_n}); else passes++;
        cyc();
        cyc();
        checks++; if (acc_cnt !== acc0 || busy !== 1'b0 || req_err !== 1'b1) $display("FAIL simul_noaccess got accesses=%0d busy=%b err=%b exp 0/0/1", acc_cnt - acc0, busy, req_err); else passes++;
        checks++; if (viol !== 0) $display("FAIL strobe_overlap got %0d exp 0", viol); else passes++;
    endtask

    initial begin
        for (int i = 0; i < 65536; i++) begin
            mem[i] = 8'(i * 7 + 3);
            exp_mem[i] = 8'(i * 7 + 3);
        end
        test_reset();
        test_read();
        test_write();
        test_back_to_back();
        test_addr_change();
        test_busy_request();
        test_reset_mid_access();
        test_simultaneous();
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
